// File: rtl/pow5_pkg.sv
// Shared constants for the x^5 engine driver: FSM encoding and default sizing.
package pow5_pkg;
  localparam int POW5_WIDTH   = 18;
  localparam int POW5_TIMEOUT = 64;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
endpackage

// File: rtl/pow_5_ref_comb.sv
// Combinational golden x^5 mod 2^WIDTH; products are truncated to WIDTH at each step.
module pow_5_ref_comb
  import pow5_pkg::*;
#(
  parameter int WIDTH = POW5_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);
  logic [WIDTH-1:0] x2, x4;

  assign x2  = x_i * x_i;
  assign x4  = x2 * x2;
  assign y_o = x4 * x_i;
endmodule

// File: rtl/pow_5_seq_driver.sv
// Run/ready initiator for the sequential x^5 engine, with watchdog and result counter.
// Optional golden-model cross-check is enabled by defining POW5_DRV_CHECK_EN.
module pow_5_seq_driver
  import pow5_pkg::*;
#(
  parameter int WIDTH   = POW5_WIDTH,
  parameter int TIMEOUT = POW5_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  output logic             run,
  output logic [WIDTH-1:0] n,
  input  logic             eng_ready,
  input  logic [WIDTH-1:0] eng_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             timeout_err,
`ifdef POW5_DRV_CHECK_EN
  output logic             mismatch,
  output logic [WIDTH-1:0] mismatch_n,
`endif
  output logic [CNT_W-1:0] done_cnt
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovld_q, ovld_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             capture;

  // reset_n gates in_ready so nothing is advertised while the engine is also held in reset
  assign in_ready    = reset_n & (state_q == S_IDLE) & eng_ready & ~err_q;
  assign run         = (state_q == S_ISSUE);
  assign n           = n_q;
  assign out_valid   = ovld_q;
  assign out_data    = data_q;
  assign timeout_err = err_q;
  assign done_cnt    = cnt_q;
  assign capture     = (state_q == S_WAIT) & eng_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    data_d  = data_q;
    ovld_d  = ovld_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: if (in_valid && in_ready) begin
        n_d     = in_n;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_ARM;
      // engine ready drops one cycle after run, so it is not trusted here
      S_ARM: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_ready) begin
          data_d  = eng_result;
          ovld_d  = 1'b1;
          state_d = S_HOLD;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_HOLD: if (out_ready) begin
        ovld_d  = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      data_q  <= '0;
      ovld_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      data_q  <= data_d;
      ovld_q  <= ovld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

`ifdef POW5_DRV_CHECK_EN
  logic [WIDTH-1:0] ref_y;
  logic             mis_q;
  logic [WIDTH-1:0] mis_n_q;

  pow_5_ref_comb #(.WIDTH(WIDTH)) u_ref (.x_i(n_q), .y_o(ref_y));

  assign mismatch   = mis_q;
  assign mismatch_n = mis_n_q;

  // only the first failing operand is kept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mis_q   <= 1'b0;
      mis_n_q <= '0;
    end else if (capture && (eng_result != ref_y) && !mis_q) begin
      mis_q   <= 1'b1;
      mis_n_q <= n_q;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif
endmodule

// File: tb/tb_pow_5_seq_driver.sv
// Bench for pow_5_seq_driver: behavioural engine, randomized ops, arithmetic reference model.
module tb_pow_5_seq_driver;
  localparam int W  = 18;
  localparam int TO = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, run, eng_ready, out_valid, out_ready, timeout_err;
  logic [W-1:0]  in_n, n, eng_result, out_data;
  logic [CW-1:0] done_cnt;
`ifdef POW5_DRV_CHECK_EN
  logic          mismatch;
  logic [W-1:0]  mismatch_n;
`endif

  int checks = 0;
  int errors = 0;
  int run_cnt;
  int eng_cnt;
  int eng_lat;
  bit eng_hang, eng_corrupt;
  logic [CW-1:0] exp_cnt;

  always #5 clock = ~clock;

  pow_5_seq_driver #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .run(run), .n(n), .eng_ready(eng_ready), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .timeout_err(timeout_err),
`ifdef POW5_DRV_CHECK_EN
    .mismatch(mismatch), .mismatch_n(mismatch_n),
`endif
    .done_cnt(done_cnt)
  );

  // reference: x^5 reduced modulo 2^W with wide arithmetic
  function automatic logic [W-1:0] ref_pow5(input logic [W-1:0] x);
    longint r = 1;
    for (int i = 0; i < 5; i++) r = (r * longint'(x)) % (longint'(1) << W);
    return W'(r);
  endfunction

  // behavioural engine: ready drops after run, returns eng_lat cycles after the run cycle
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eng_ready  <= 1'b1;
      eng_cnt    <= 0;
      eng_result <= '0;
      run_cnt    <= 0;
    end else if (run) begin
      eng_ready <= 1'b0;
      eng_cnt   <= eng_lat - 1;
      run_cnt   <= run_cnt + 1;
    end else if (eng_cnt != 0 && !eng_hang) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_ready  <= 1'b1;
        eng_result <= ref_pow5(n) ^ ((eng_corrupt && n == W'(5)) ? W'(1) : W'(0));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_run", 32'(run), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_n", 32'(n), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_cnt", 32'(done_cnt), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    exp_cnt = '0;
    tick();
  endtask

  // one full operation; bp = cycles of downstream backpressure in HOLD
  task automatic do_op(input logic [W-1:0] x, input int lat, input int bp,
                       input logic [W-1:0] exp_d, input bit chk_lat);
    int t;
    logic [W-1:0] held;
    eng_lat  = lat;
    in_n     = x;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin tick(); t++; end
    if (t >= 100) chk("accept_timeout", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_n     = W'($urandom);
    chk("issue_run", 32'(run), 1);
    chk("issue_n", 32'(n), 32'(x));
    tick();
    chk("arm_run_low", 32'(run), 0);
    t = 1;
    while (!out_valid && t < 100) begin tick(); t++; end
    if (chk_lat) chk("run_to_valid", 32'(t), 32'(lat + 1));
    chk("out_data", 32'(out_data), 32'(exp_d));
    held = out_data;
    in_valid = 1'b1;
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_run", 32'(run), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    chk("accept_valid_low", 32'(out_valid), 0);
    chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [W-1:0] x;
    int t, r0;
    in_valid = 0; out_ready = 0; in_n = '0;
    eng_lat = 4; eng_hang = 0; eng_corrupt = 0;
    exp_cnt = '0;
    do_reset();

    do_op(W'(3), 4, 0, W'(243), 1);

    r0 = run_cnt;
    for (int i = 0; i < 8; i++) do_op(W'(i), 3, 0, ref_pow5(W'(i)), 1);
    chk("stream_runs", 32'(run_cnt - r0), 8);
    chk("stream_cnt", 32'(done_cnt), 9);

    do_op(W'(20), 2, 0, W'(54272), 1);
    do_op(W'(262143), 5, 0, W'(262143), 1);
    do_op(W'(7), 4, 10, W'(16807), 1);

    for (int i = 0; i < 20; i++) begin
      x = W'($urandom);
      do_op(x, $urandom_range(2, 6), $urandom_range(0, 3), ref_pow5(x), 1);
    end

    // watchdog: engine never returns
    eng_hang = 1; eng_lat = 4;
    in_n = W'(9); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("to_run", 32'(run), 1);
    t = 0;
    while (!timeout_err && t < 100) begin
      tick(); t++;
      chk("to_no_valid", 32'(out_valid), 0);
    end
    chk("to_cycles", 32'(t), 10);
    eng_hang = 0;
    in_valid = 1'b1;
    repeat (6) begin
      tick();
      chk("to_halt_ready", 32'(in_ready), 0);
      chk("to_halt_run", 32'(run), 0);
      chk("to_sticky", 32'(timeout_err), 1);
    end
    in_valid = 1'b0;
    do_reset();
    do_op(W'(11), 3, 0, ref_pow5(W'(11)), 1);

    // asynchronous reset while the engine is busy
    eng_lat = 6;
    in_n = W'(4); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_run", 32'(run), 0);
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_cnt", 32'(done_cnt), 0);
    chk("mid_err", 32'(timeout_err), 0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_cnt = '0;
    tick();
    do_op(W'(6), 4, 1, W'(7776), 1);

`ifdef POW5_DRV_CHECK_EN
    eng_corrupt = 1;
    do_op(W'(5), 3, 0, W'(3124), 1);
    chk("mismatch", 32'(mismatch), 1);
    chk("mismatch_n", 32'(mismatch_n), 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
